// File: rtl/dsm_pkg.sv
// Shared constants, FSM encoding and width helpers for the sinc3 decimator.
package dsm_pkg;

    localparam int unsigned MOD_BITS_DEFAULT = 4;
    localparam int unsigned FILL_TICKS       = 3;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // CIC bit growth: N*log2(R) for N=3 stages on top of the input width.
    function automatic int unsigned acc_bits(input int unsigned mod_bits,
                                             input int unsigned decim_log2);
        return mod_bits + 3 * decim_log2;
    endfunction

endpackage

// File: rtl/dsm_cic_comb.sv
// One CIC differentiator stage: y = x - x_prev, where x_prev updates on en.
module dsm_cic_comb #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] d;

    always_comb begin
        y = x - d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d <= '0;
        end else if (en) begin
            d <= x;
        end
    end

endmodule

// File: rtl/dsm_sinc3_decimator.sv
// Sinc3 (3rd-order CIC) decimator by 2^DECIM_LOG2 with valid/ready output.
// Optional DSM_DECIM_OVF_CNT_EN adds a saturating dropped-sample counter port.
module dsm_sinc3_decimator
    import dsm_pkg::*;
#(
    parameter int unsigned MOD_BITS   = MOD_BITS_DEFAULT,
    parameter int unsigned DECIM_LOG2 = 4,
    parameter int unsigned OUT_BITS   = 16
) (
    input  logic                internal_clk,
    input  logic                internal_rst,
    input  logic                in_valid,
    input  logic [MOD_BITS-1:0] in_bit,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                settled,
`ifdef DSM_DECIM_OVF_CNT_EN
    output logic [7:0]          ovf_count,
`endif
    output logic                overrun
);

    localparam int unsigned ACC_BITS  = acc_bits(MOD_BITS, DECIM_LOG2);
    localparam int unsigned WARM_BITS = clog2(FILL_TICKS);

    logic [ACC_BITS-1:0]   i1, i2, i3;
    logic [ACC_BITS-1:0]   c1, c2, c3;
    logic [DECIM_LOG2-1:0] phase;
    logic                  tick;
    logic [WARM_BITS-1:0]  warm;
    state_t                state;
    logic                  accept;

    // Integrators run at the input rate; wrap-around is intentional.
    always_ff @(posedge internal_clk) begin
        if (internal_rst) begin
            i1    <= '0;
            i2    <= '0;
            i3    <= '0;
            phase <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= in_valid && (phase == '1);
            if (in_valid) begin
                i1    <= i1 + ACC_BITS'(in_bit);
                i2    <= i2 + i1;
                i3    <= i3 + i2;
                phase <= phase + DECIM_LOG2'(1);
            end
        end
    end

    dsm_cic_comb #(.WIDTH(ACC_BITS)) u_comb1 (
        .clk(internal_clk), .rst(internal_rst), .en(tick), .x(i3), .y(c1)
    );

    dsm_cic_comb #(.WIDTH(ACC_BITS)) u_comb2 (
        .clk(internal_clk), .rst(internal_rst), .en(tick), .x(c1), .y(c2)
    );

    dsm_cic_comb #(.WIDTH(ACC_BITS)) u_comb3 (
        .clk(internal_clk), .rst(internal_rst), .en(tick), .x(c2), .y(c3)
    );

    always_comb begin
        accept = out_valid && out_ready;
    end

    always_ff @(posedge internal_clk) begin
        if (internal_rst) begin
            state     <= S_FILL;
            warm      <= '0;
            settled   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef DSM_DECIM_OVF_CNT_EN
            ovf_count <= '0;
`endif
        end else begin
            if (accept) begin
                out_valid <= 1'b0;
            end
            if (tick) begin
                if (state == S_FILL) begin
                    warm <= warm + WARM_BITS'(1);
                    if (warm == WARM_BITS'(FILL_TICKS - 1)) begin
                        state   <= S_RUN;
                        settled <= 1'b1;
                    end
                end else begin
                    // A slot freed by a same-cycle accept can take the new result.
                    if (!out_valid || accept) begin
                        out_data  <= c3[ACC_BITS-1 -: OUT_BITS];
                        out_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
`ifdef DSM_DECIM_OVF_CNT_EN
                        if (ovf_count != '1) begin
                            ovf_count <= ovf_count + 8'd1;
                        end
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dsm_sinc3_decimator.sv
// Directed self-checking bench for dsm_sinc3_decimator at default parameters.
module tb_dsm_sinc3_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_bit;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        settled;
    logic        overrun;
    logic [7:0]  ovf_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dsm_sinc3_decimator dut (
        .internal_clk(clk),
        .internal_rst(rst),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .settled(settled),
`ifdef DSM_DECIM_OVF_CNT_EN
        .ovf_count(ovf_count),
`endif
        .overrun(overrun)
    );

`ifndef DSM_DECIM_OVF_CNT_EN
    assign ovf_count = 8'd0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_bit = 4'd0; out_ready = 1'b0;
        step_n(2);
        rst = 1'b0;
    endtask

    // Streams constant x from a freshly reset filter and checks timing/values of 4 outputs.
    task automatic run_stream(input string name, input logic [3:0] x, input bit toggle,
                              input int exp_settle, input int exp_first,
                              input int exp_period, input logic [15:0] exp_val);
        int n, settle_at, last_at, got;
        n = 0; settle_at = -1; last_at = -1; got = 0;
        in_bit = x; out_ready = 1'b1;
        while (got < 4 && n < 400) begin
            in_valid = toggle ? (n % 2 == 0) : 1'b1;
            step();
            n++;
            if (settled === 1'b1 && settle_at < 0) settle_at = n;
            if (out_valid === 1'b1) begin
                checks++;
                if (got == 0) begin
                    if (n !== exp_first) begin
                        errors++;
                        $display("FAIL %s first_out_edge: got %0d expected %0d", name, n, exp_first);
                    end
                end else if (n - last_at !== exp_period) begin
                    errors++;
                    $display("FAIL %s out_period: got %0d expected %0d", name, n - last_at, exp_period);
                end
                checks++;
                if (out_data !== exp_val) begin
                    errors++;
                    $display("FAIL %s out_data[%0d]: got %0d expected %0d", name, got, out_data, exp_val);
                end
                last_at = n;
                got++;
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL %s timeout: got %0d outputs expected 4", name, got);
        end
        checks++;
        if (settle_at !== exp_settle) begin
            errors++;
            $display("FAIL %s settle_edge: got %0d expected %0d", name, settle_at, exp_settle);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL %s overrun: got %b expected 0", name, overrun);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || settled !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b settled=%b overrun=%b expected 0 0 0",
                     out_valid, settled, overrun);
        end
        checks++;
        if (out_data !== 16'd0 || ovf_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got data=%0d ovf=%0d expected 0 0", out_data, ovf_count);
        end
    endtask

    task automatic test_constant();
        do_reset();
        run_stream("full_scale", 4'd15, 1'b0, 49, 65, 16, 16'd61440);
        do_reset();
        run_stream("mid_scale", 4'd8, 1'b0, 49, 65, 16, 16'd32768);
        do_reset();
        run_stream("zero", 4'd0, 1'b0, 49, 65, 16, 16'd0);
    endtask

    task automatic test_toggle_valid();
        do_reset();
        run_stream("half_rate", 4'd15, 1'b1, 96, 128, 32, 16'd61440);
    endtask

    task automatic test_overrun();
        do_reset();
        in_bit = 4'd8; in_valid = 1'b1; out_ready = 1'b1;
        step_n(80);
        out_ready = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd32768 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_load: got valid=%b data=%0d overrun=%b expected 1 32768 0",
                     out_valid, out_data, overrun);
        end
        in_bit = 4'd15;
        step_n(16);
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'd32768) begin
            errors++;
            $display("FAIL ovr_first_drop: got overrun=%b valid=%b data=%0d expected 1 1 32768",
                     overrun, out_valid, out_data);
        end
`ifdef DSM_DECIM_OVF_CNT_EN
        checks++;
        if (ovf_count !== 8'd1) begin
            errors++;
            $display("FAIL ovf_count_1: got %0d expected 1", ovf_count);
        end
`endif
        step_n(64);
        checks++;
        if (out_data !== 16'd32768 || out_valid !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_held: got data=%0d valid=%b overrun=%b expected 32768 1 1",
                     out_data, out_valid, overrun);
        end
`ifdef DSM_DECIM_OVF_CNT_EN
        checks++;
        if (ovf_count !== 8'd5) begin
            errors++;
            $display("FAIL ovf_count_5: got %0d expected 5", ovf_count);
        end
`endif
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drain: got valid=%b expected 0", out_valid);
        end
        step_n(15);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd61440 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_next: got valid=%b data=%0d overrun=%b expected 1 61440 1",
                     out_valid, out_data, overrun);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_bit = 4'd15; in_valid = 1'b1; out_ready = 1'b1;
        step_n(80);
        out_ready = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_held: got valid=%b expected 1", out_valid);
        end
        step_n(15);
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd61440 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reload: got valid=%b data=%0d overrun=%b expected 1 61440 0",
                     out_valid, out_data, overrun);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got valid=%b expected 0", out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_bit = 4'd15; in_valid = 1'b1; out_ready = 1'b0;
        step_n(85);
        checks++;
        if (out_valid !== 1'b1 || overrun !== 1'b1 || settled !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got valid=%b overrun=%b settled=%b expected 1 1 1",
                     out_valid, overrun, settled);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || settled !== 1'b0 || overrun !== 1'b0 || out_data !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b settled=%b overrun=%b data=%0d expected 0 0 0 0",
                     out_valid, settled, overrun, out_data);
        end
        run_stream("reprime", 4'd15, 1'b0, 49, 65, 16, 16'd61440);
    endtask

    initial begin
        test_reset();
        test_constant();
        test_toggle_valid();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
